// File: rtl/cpu6502_fetch_pkg.sv
// Shared fetch-stage types: FSM state encoding, instruction length type and the
// opcode length decoder (also usable by the addressing-mode stage).
`timescale 1ns/1ps
package cpu6502_fetch_pkg;

    typedef logic [1:0] len_t;

    localparam len_t LEN_1 = 2'd1;
    localparam len_t LEN_2 = 2'd2;
    localparam len_t LEN_3 = 2'd3;

    typedef enum logic [3:0] {
        S_START,
        S_OP,
        S_B1,
        S_B2,
        S_B3,
        S_OUT,
        S_VLO,
        S_VHI,
        S_VLD
    } fetch_state_t;

    // Decoded by the low nibble first; illegal columns 3/7/B/F fall to one byte.
    function automatic len_t opcode_length(input logic [7:0] op);
        len_t len;
        len = LEN_1;
        case (op[3:0])
            4'h0: begin
                if (op == 8'h20)
                    len = LEN_3;
                else if ((op == 8'h00) || (op == 8'h40) || (op == 8'h60))
                    len = LEN_1;
                else
                    len = LEN_2;
            end
            4'h1, 4'h4, 4'h5, 4'h6: len = LEN_2;
            4'h2:                   len = (op == 8'hA2) ? LEN_2 : LEN_1;
            4'h9:                   len = op[4] ? LEN_3 : LEN_2;
            4'hC, 4'hD, 4'hE:       len = LEN_3;
            default:                len = LEN_1;
        endcase
        return len;
    endfunction

endpackage

// File: rtl/instruction_fetch_unit.sv
// 6502 instruction fetch: reads opcode plus 0-2 operand bytes and hands a bundle
// downstream over valid/ready. Define RESET_VECTOR_FETCH_EN to load pc from the reset vector.
`timescale 1ns/1ps
module instruction_fetch_unit
    import cpu6502_fetch_pkg::*;
#(
    parameter logic [15:0] RESET_PC    = 16'h0200,
    parameter logic [15:0] VECTOR_ADDR = 16'hFFFC
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [15:0] mem_addr,
    output logic        mem_rd_en,
    input  logic [7:0]  mem_rdata,
    input  logic        redirect_valid,
    input  logic [15:0] redirect_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [15:0] instr_pc,
    output logic [7:0]  opcode,
    output logic [7:0]  operand1,
    output logic [7:0]  operand2,
    output logic [1:0]  instr_length
);

    fetch_state_t state_reg, state_next;
    logic [15:0]  pc_reg, pc_next;
    logic [15:0]  instr_pc_reg, instr_pc_next;
    logic [7:0]   opcode_reg, opcode_next;
    logic [7:0]   operand1_reg, operand1_next;
    logic [7:0]   operand2_reg, operand2_next;
    len_t         len_reg, len_next;
    logic [7:0]   vec_lo_reg, vec_lo_next;
    logic [15:0]  mem_addr_reg;

    logic [15:0]  pc_plus1;
    logic [15:0]  pc_plus2;
    logic [15:0]  pc_advance;
    len_t         rdata_len;

    assign pc_plus1   = pc_reg + 16'd1;
    assign pc_plus2   = pc_reg + 16'd2;
    assign pc_advance = pc_reg + {14'd0, len_reg};
    assign rdata_len  = opcode_length(mem_rdata);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= S_START;
            pc_reg       <= RESET_PC;
            instr_pc_reg <= 16'd0;
            opcode_reg   <= 8'd0;
            operand1_reg <= 8'd0;
            operand2_reg <= 8'd0;
            len_reg      <= 2'd0;
            vec_lo_reg   <= 8'd0;
            mem_addr_reg <= 16'd0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            instr_pc_reg <= instr_pc_next;
            opcode_reg   <= opcode_next;
            operand1_reg <= operand1_next;
            operand2_reg <= operand2_next;
            len_reg      <= len_next;
            vec_lo_reg   <= vec_lo_next;
            mem_addr_reg <= mem_addr;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        instr_pc_next = instr_pc_reg;
        opcode_next   = opcode_reg;
        operand1_next = operand1_reg;
        operand2_next = operand2_reg;
        len_next      = len_reg;
        vec_lo_next   = vec_lo_reg;
        mem_rd_en     = 1'b0;
        mem_addr      = mem_addr_reg;

        case (state_reg)
            S_START: begin
`ifdef RESET_VECTOR_FETCH_EN
                state_next = S_VLO;
`else
                state_next = S_OP;
`endif
            end
            // Vector states are unreachable unless the vector fetch is compiled in.
            S_VLO: begin
                mem_rd_en  = 1'b1;
                mem_addr   = VECTOR_ADDR;
                state_next = S_VHI;
            end
            S_VHI: begin
                mem_rd_en   = 1'b1;
                mem_addr    = VECTOR_ADDR + 16'd1;
                vec_lo_next = mem_rdata;
                state_next  = S_VLD;
            end
            S_VLD: begin
                pc_next    = {mem_rdata, vec_lo_reg};
                state_next = S_OP;
            end
            S_OP: begin
                mem_rd_en  = 1'b1;
                mem_addr   = pc_reg;
                state_next = S_B1;
            end
            S_B1: begin
                instr_pc_next = pc_reg;
                opcode_next   = mem_rdata;
                len_next      = rdata_len;
                operand1_next = 8'd0;
                operand2_next = 8'd0;
                if (rdata_len == LEN_1) begin
                    state_next = S_OUT;
                end else begin
                    mem_rd_en  = 1'b1;
                    mem_addr   = pc_plus1;
                    state_next = S_B2;
                end
            end
            S_B2: begin
                operand1_next = mem_rdata;
                if (len_reg == LEN_3) begin
                    mem_rd_en  = 1'b1;
                    mem_addr   = pc_plus2;
                    state_next = S_B3;
                end else begin
                    state_next = S_OUT;
                end
            end
            S_B3: begin
                operand2_next = mem_rdata;
                state_next    = S_OUT;
            end
            S_OUT: begin
                if (instr_ready) begin
                    pc_next    = pc_advance;
                    state_next = S_OP;
                end
            end
            default: state_next = S_START;
        endcase

        // A redirect abandons whatever is in flight; the bundle registers keep their old
        // contents so nothing half-fetched leaks onto the outputs.
        if (redirect_valid) begin
            pc_next       = redirect_pc;
            state_next    = S_OP;
            instr_pc_next = instr_pc_reg;
            opcode_next   = opcode_reg;
            operand1_next = operand1_reg;
            operand2_next = operand2_reg;
            len_next      = len_reg;
            vec_lo_next   = vec_lo_reg;
        end
    end

    assign instr_valid  = (state_reg == S_OUT);
    assign instr_pc     = instr_pc_reg;
    assign opcode       = opcode_reg;
    assign operand1     = operand1_reg;
    assign operand2     = operand2_reg;
    assign instr_length = len_reg;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed vector table, multi-cycle
// corner sequences and a randomized run against a transaction-level reference model.
`timescale 1ns/1ps
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] mem_addr;
    logic        mem_rd_en;
    logic [7:0]  mem_rdata;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr_pc;
    logic [7:0]  opcode;
    logic [7:0]  operand1;
    logic [7:0]  operand2;
    logic [1:0]  instr_length;

    always #5 clk = ~clk;

    instruction_fetch_unit dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .mem_addr       (mem_addr),
        .mem_rd_en      (mem_rd_en),
        .mem_rdata      (mem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_pc       (instr_pc),
        .opcode         (opcode),
        .operand1       (operand1),
        .operand2       (operand2),
        .instr_length   (instr_length)
    );

    // Program memory: one-cycle read latency, garbage on the bus when not reading.
    logic [7:0] mem [0:65535];
    always @(posedge clk) mem_rdata <= mem_rd_en ? mem[mem_addr] : 8'($urandom);

    int errors = 0;
    int checks = 0;
    int ref_len [256];
    logic [15:0] rd_q [$];
    int lat;

    typedef struct {
        logic [15:0] pc;
        logic [7:0]  b0, b1, b2;
        logic [7:0]  e1, e2;
        logic [1:0]  elen;
    } vec_t;
    vec_t vecs [16];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(negedge clk);
    endtask

    function automatic logic [63:0] pack_b(input logic [15:0] pc, input logic [7:0] op,
                                           input logic [7:0] o1, input logic [7:0] o2,
                                           input logic [1:0] len);
        return {22'd0, pc, op, o1, o2, len};
    endfunction

    function automatic logic [63:0] bundle_now();
        return pack_b(instr_pc, opcode, operand1, operand2, instr_length);
    endfunction

    function automatic logic [63:0] outs_now();
        return {4'd0, instr_valid, mem_rd_en, mem_addr, instr_pc, opcode, operand1, operand2, instr_length};
    endfunction

    // What the bundle fetched from address pc must contain, straight from memory.
    function automatic logic [63:0] model_bundle(input logic [15:0] pc);
        logic [1:0]  len;
        logic [15:0] a1, a2;
        len = 2'(ref_len[mem[pc]]);
        a1  = pc + 16'd1;
        a2  = pc + 16'd2;
        return pack_b(pc, mem[pc], (len >= 2'd2) ? mem[a1] : 8'h00, (len == 2'd3) ? mem[a2] : 8'h00, len);
    endfunction

    task automatic wait_valid(input string name);
        rd_q.delete();
        lat = 0;
        while (!instr_valid && lat < 20) begin
            if (mem_rd_en) rd_q.push_back(mem_addr);
            cycle();
            lat++;
        end
        check({name, " valid"}, 64'(instr_valid), 64'd1);
    endtask

    // Call on the cycle the fetch begins (fresh fetch address on the bus).
    task automatic expect_bundle(input string name, input logic [15:0] pc, input logic [7:0] op,
                                 input logic [7:0] o1, input logic [7:0] o2, input logic [1:0] len);
        logic [63:0] got_r;
        logic [63:0] exp_r;
        logic [15:0] a;
        wait_valid(name);
        check({name, " bundle"}, bundle_now(), pack_b(pc, op, o1, o2, len));
        check({name, " latency"}, 64'(lat), 64'(len) + 64'd1);
        got_r = 64'(rd_q.size()) << 48;
        exp_r = 64'(len) << 48;
        for (int i = 0; i < rd_q.size() && i < 3; i++) got_r[16*i +: 16] = rd_q[i];
        for (int i = 0; i < int'(len); i++) begin
            a = pc + 16'(i);
            exp_r[16*i +: 16] = a;
        end
        check({name, " reads"}, got_r, exp_r);
        $display("%s: pc=%h op=%h op1=%h op2=%h len=%0d latency=%0d",
                 name, instr_pc, opcode, operand1, operand2, instr_length, lat);
    endtask

    task automatic accept();
        instr_ready = 1'b1;
        cycle();
        instr_ready = 1'b0;
    endtask

    task automatic redirect_to(input logic [15:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        cycle();
        redirect_valid = 1'b0;
    endtask

`ifdef RESET_VECTOR_FETCH_EN
    task automatic vector_start(input string name);
        logic [63:0] got_r;
        int n;
        rd_q.delete();
        n = 0;
        while (!(mem_rd_en && mem_addr != 16'hFFFC && mem_addr != 16'hFFFD) && n < 20) begin
            if (mem_rd_en) rd_q.push_back(mem_addr);
            cycle();
            n++;
        end
        got_r = 64'(rd_q.size()) << 48;
        for (int i = 0; i < rd_q.size() && i < 3; i++) got_r[16*i +: 16] = rd_q[i];
        check({name, " vector reads"}, got_r, {16'd2, 16'd0, 16'hFFFD, 16'hFFFC});
        check({name, " first opcode addr"}, {47'd0, mem_rd_en, mem_addr}, {47'd0, 1'b1, 16'h8000});
        $display("%s: vector reads=%0d first fetch at %h", name, rd_q.size(), mem_addr);
    endtask
`endif

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [63:0] snap;
        logic [15:0] a, np, mpc, rpc;
        logic ready, redir, prev_redir;
        int idle, ntx;

        vecs[0]  = '{16'h0300, 8'hEA, 8'h5A, 8'hC3, 8'h00, 8'h00, 2'd1};
        vecs[1]  = '{16'h0310, 8'h00, 8'h11, 8'h22, 8'h00, 8'h00, 2'd1};
        vecs[2]  = '{16'h0320, 8'h20, 8'h34, 8'h12, 8'h34, 8'h12, 2'd3};
        vecs[3]  = '{16'h0330, 8'h40, 8'h77, 8'h88, 8'h00, 8'h00, 2'd1};
        vecs[4]  = '{16'h0334, 8'h60, 8'h77, 8'h88, 8'h00, 8'h00, 2'd1};
        vecs[5]  = '{16'h0340, 8'h10, 8'h05, 8'h99, 8'h05, 8'h00, 2'd2};
        vecs[6]  = '{16'h0350, 8'hA2, 8'h07, 8'h99, 8'h07, 8'h00, 2'd2};
        vecs[7]  = '{16'h0360, 8'h02, 8'h66, 8'h99, 8'h00, 8'h00, 2'd1};
        vecs[8]  = '{16'h0370, 8'h09, 8'h44, 8'h99, 8'h44, 8'h00, 2'd2};
        vecs[9]  = '{16'h0380, 8'h19, 8'h11, 8'h22, 8'h11, 8'h22, 2'd3};
        vecs[10] = '{16'h0390, 8'h4C, 8'h00, 8'h03, 8'h00, 8'h03, 2'd3};
        vecs[11] = '{16'hFFFF, 8'hE8, 8'h5A, 8'hC3, 8'h00, 8'h00, 2'd1};
        vecs[12] = '{16'hFFFE, 8'h4C, 8'h11, 8'h22, 8'h11, 8'h22, 2'd3};
        vecs[13] = '{16'h03A0, 8'h85, 8'h10, 8'h99, 8'h10, 8'h00, 2'd2};
        vecs[14] = '{16'h03B0, 8'hB7, 8'h55, 8'h66, 8'h00, 8'h00, 2'd1};
        vecs[15] = '{16'h03C0, 8'h0E, 8'hAA, 8'hBB, 8'hAA, 8'hBB, 2'd3};

        for (int op = 0; op < 256; op++) begin
            int lo, hi;
            lo = op % 16;
            hi = op / 16;
            if (op == 'h20 || (lo >= 12 && lo <= 14) || (lo == 9 && hi % 2 == 1))
                ref_len[op] = 3;
            else if (op == 'h00 || op == 'h40 || op == 'h60 || (lo == 2 && op != 'hA2) ||
                     lo == 8 || lo == 10 || lo % 4 == 3)
                ref_len[op] = 1;
            else
                ref_len[op] = 2;
        end
        for (int i = 0; i < 65536; i++) mem[i] = 8'($urandom);
        mem[16'h0200] = 8'hA9; mem[16'h0201] = 8'h42;
        mem[16'h0202] = 8'hAD; mem[16'h0203] = 8'h34; mem[16'h0204] = 8'h12;
`ifdef RESET_VECTOR_FETCH_EN
        mem[16'hFFFC] = 8'h00; mem[16'hFFFD] = 8'h80; mem[16'h8000] = 8'hEA;
`endif

        rst_n = 1'b0;
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 16'h0000;
        repeat (3) cycle();
        check("reset outputs", outs_now(), 64'd0);
        rst_n = 1'b1;
        check("start no read", 64'(mem_rd_en), 64'd0);

`ifdef RESET_VECTOR_FETCH_EN
        vector_start("vector boot");
        expect_bundle("vector first", 16'h8000, 8'hEA, 8'h00, 8'h00, 2'd1);
        accept();
        redirect_to(16'h0200);
`else
        cycle();
`endif
        // LDA #imm from the reset PC
        expect_bundle("t1 lda", 16'h0200, 8'hA9, 8'h42, 8'h00, 2'd2);
        accept();
        check("t1 next fetch", {47'd0, mem_rd_en, mem_addr}, {47'd0, 1'b1, 16'h0202});

        // LDA abs held under backpressure
        expect_bundle("t2 lda abs", 16'h0202, 8'hAD, 8'h34, 8'h12, 2'd3);
        snap = bundle_now();
        for (int i = 0; i < 5; i++) begin
            cycle();
            check("t2 stall valid", 64'(instr_valid), 64'd1);
            check("t2 stall bundle", bundle_now(), snap);
        end
        accept();
        check("t2 next fetch", {47'd0, mem_rd_en, mem_addr}, {47'd0, 1'b1, 16'h0205});

        for (int i = 0; i < 16; i++) begin
            a = vecs[i].pc;
            mem[a] = vecs[i].b0;
            a = vecs[i].pc + 16'd1;
            mem[a] = vecs[i].b1;
            a = vecs[i].pc + 16'd2;
            mem[a] = vecs[i].b2;
            redirect_to(vecs[i].pc);
            expect_bundle($sformatf("vec%0d", i), vecs[i].pc, vecs[i].b0, vecs[i].e1, vecs[i].e2, vecs[i].elen);
            accept();
            np = vecs[i].pc + 16'(vecs[i].elen);
            check($sformatf("vec%0d next fetch", i), {47'd0, mem_rd_en, mem_addr}, {47'd0, 1'b1, np});
        end

        // Redirect while the second operand read is on the bus
        mem[16'h0400] = 8'h20; mem[16'h0401] = 8'h01; mem[16'h0402] = 8'h02;
        mem[16'h0300] = 8'hEA;
        redirect_to(16'h0400);
        cycle();
        cycle();
        check("t4 in operand2 read", {47'd0, mem_rd_en, mem_addr}, {47'd0, 1'b1, 16'h0402});
        redirect_to(16'h0300);
        check("t4 redirect fetch", {46'd0, instr_valid, mem_rd_en, mem_addr}, {46'd0, 1'b0, 1'b1, 16'h0300});
        expect_bundle("t4 after redirect", 16'h0300, 8'hEA, 8'h00, 8'h00, 2'd1);

        // Redirect coinciding with the handshake
        mem[16'h0500] = 8'hA9; mem[16'h0501] = 8'h77;
        instr_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 16'h0500;
        cycle();
        instr_ready = 1'b0;
        redirect_valid = 1'b0;
        check("t5 redirect wins", {46'd0, instr_valid, mem_rd_en, mem_addr}, {46'd0, 1'b0, 1'b1, 16'h0500});
        expect_bundle("t5 after redirect", 16'h0500, 8'hA9, 8'h77, 8'h00, 2'd2);
        accept();

        // Asynchronous reset in the middle of a fetch
        redirect_to(16'h0320);
        cycle();
        rst_n = 1'b0;
        #1;
        check("reset mid-fetch", outs_now(), 64'd0);
        cycle();
        rst_n = 1'b1;
        check("restart no read", 64'(mem_rd_en), 64'd0);
`ifdef RESET_VECTOR_FETCH_EN
        vector_start("vector restart");
        expect_bundle("vector restart first", 16'h8000, 8'hEA, 8'h00, 8'h00, 2'd1);
`else
        cycle();
        expect_bundle("restart", 16'h0200, 8'hA9, 8'h42, 8'h00, 2'd2);
`endif
        accept();

        // Randomized run against the transaction model
        mpc = 16'($urandom);
        redirect_to(mpc);
        idle = 0;
        ntx = 0;
        prev_redir = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            if (prev_redir) check("rand valid after redirect", 64'(instr_valid), 64'd0);
            if (instr_valid) begin
                check("rand bundle", bundle_now(), model_bundle(mpc));
                idle = 0;
            end else begin
                idle++;
                if (idle > 6) begin
                    checks++;
                    errors++;
                    $display("FAIL rand progress: no bundle for %0d cycles, required at most 6", idle);
                    idle = 0;
                end
            end
            ready = ($urandom_range(0, 2) != 0);
            redir = ($urandom_range(0, 24) == 0);
            rpc   = 16'($urandom);
            instr_ready    = ready;
            redirect_valid = redir;
            redirect_pc    = rpc;
            if (instr_valid && ready) begin
                ntx++;
                $display("rand tx %0d: pc=%h op=%h len=%0d%s", ntx, instr_pc, opcode, instr_length,
                         redir ? " (with redirect)" : "");
            end
            if (redir) begin
                mpc  = rpc;
                idle = 0;
            end else if (instr_valid && ready) begin
                mpc = mpc + 16'(ref_len[mem[mpc]]);
            end
            prev_redir = redir;
            cycle();
        end
        instr_ready = 1'b0;
        redirect_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
